// File: rtl/hopfield_sequencer.sv
// Training / recall controller for a 7-neuron Hopfield network: replays stored
// 4-bit patterns with learning on, or injects a cue and thresholds spike counts.
module hopfield_sequencer #(
   parameter int N_PAT         = 4,
   parameter int EPOCHS        = 8,
   parameter int TRAIN_CYCLES  = 200,
   parameter int REST_CYCLES   = 50,
   parameter int CUE_CYCLES    = 20,
   parameter int RECALL_CYCLES = 500,
   parameter int SPIKE_THRESH  = 3,
   parameter int CNT_W         = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     pat_wr_en,
   input  logic [$clog2(N_PAT)-1:0] pat_wr_addr,
   input  logic [3:0]               pat_wr_data,
   input  logic                     train_start,
   input  logic                     recall_start,
   input  logic [3:0]               cue,
   input  logic                     abort,
   input  logic [6:0]               spikes,
   output logic                     learning_enable,
   output logic [3:0]               pattern_input,
   output logic                     busy,
   output logic                     done,
   output logic [6:0]               recall_result
);

   localparam int IW     = $clog2(N_PAT);
   localparam int EW     = (EPOCHS > 1) ? $clog2(EPOCHS) : 1;
   localparam int TMAX_A = (TRAIN_CYCLES > REST_CYCLES) ? TRAIN_CYCLES : REST_CYCLES;
   localparam int TMAX_B = (CUE_CYCLES > RECALL_CYCLES) ? CUE_CYCLES : RECALL_CYCLES;
   localparam int TMAX   = (TMAX_A > TMAX_B) ? TMAX_A : TMAX_B;
   localparam int TW     = $clog2(TMAX + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic [2:0] {IDLE, T_PRESENT, T_REST, CUE, RECALL, REPORT} state_t;

   state_t           state;
   logic [3:0]       mem [N_PAT];
   logic [IW-1:0]    pat_idx;
   logic [IW-1:0]    next_idx;
   logic [EW-1:0]    epoch;
   logic [TW-1:0]    timer;
   logic [6:0]       prev;
   logic [CNT_W-1:0] cnt      [7];
   logic [CNT_W-1:0] cnt_next [7];

   assign next_idx = pat_idx + 1'b1;

   // NOTE: the report decision needs the count including the final RECALL
   // cycle, so the incremented values are formed combinationally and reused.
   always_comb begin
      for (int k = 0; k < 7; k++) begin
         cnt_next[k] = cnt[k];
         if (state == RECALL && spikes[k] && !prev[k] && cnt[k] != CNT_MAX)
            cnt_next[k] = cnt[k] + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state           <= IDLE;
         pat_idx         <= '0;
         epoch           <= '0;
         timer           <= '0;
         prev            <= '0;
         learning_enable <= 1'b0;
         pattern_input   <= '0;
         busy            <= 1'b0;
         done            <= 1'b0;
         recall_result   <= '0;
         // NOTE: the pattern store is only N_PAT nibbles and must read back as
         // zero after any reset, so it lives in resettable flops, not a RAM.
         for (int i = 0; i < N_PAT; i++) mem[i] <= '0;
         for (int k = 0; k < 7; k++) cnt[k] <= '0;
      end else begin
         done <= 1'b0;
         if (abort) begin
            state           <= IDLE;
            busy            <= 1'b0;
            learning_enable <= 1'b0;
            pattern_input   <= '0;
         end else begin
            case (state)
               IDLE: begin
                  if (train_start) begin
                     state           <= T_PRESENT;
                     busy            <= 1'b1;
                     pat_idx         <= '0;
                     epoch           <= '0;
                     learning_enable <= 1'b1;
                     pattern_input   <= mem[0];
                     timer           <= TW'(TRAIN_CYCLES - 1);
                  end else if (recall_start) begin
                     state           <= CUE;
                     busy            <= 1'b1;
                     learning_enable <= 1'b1;
                     pattern_input   <= cue;
                     timer           <= TW'(CUE_CYCLES - 1);
                     prev            <= '0;
                     for (int k = 0; k < 7; k++) cnt[k] <= '0;
                  end else if (pat_wr_en) begin
                     mem[pat_wr_addr] <= pat_wr_data;
                  end
               end
               T_PRESENT: begin
                  if (timer == '0) begin
                     state           <= T_REST;
                     learning_enable <= 1'b0;
                     pattern_input   <= '0;
                     timer           <= TW'(REST_CYCLES - 1);
                  end else begin
                     timer <= timer - 1'b1;
                  end
               end
               T_REST: begin
                  if (timer != '0) begin
                     timer <= timer - 1'b1;
                  end else if (pat_idx == IW'(N_PAT - 1) && epoch == EW'(EPOCHS - 1)) begin
                     state <= IDLE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end else begin
                     if (pat_idx == IW'(N_PAT - 1)) epoch <= epoch + 1'b1;
                     pat_idx         <= next_idx;
                     state           <= T_PRESENT;
                     learning_enable <= 1'b1;
                     pattern_input   <= mem[next_idx];
                     timer           <= TW'(TRAIN_CYCLES - 1);
                  end
               end
               CUE: begin
                  if (timer == '0) begin
                     state           <= RECALL;
                     learning_enable <= 1'b0;
                     pattern_input   <= '0;
                     prev            <= '0;
                     timer           <= TW'(RECALL_CYCLES - 1);
                  end else begin
                     timer <= timer - 1'b1;
                  end
               end
               RECALL: begin
                  cnt  <= cnt_next;
                  prev <= spikes;
                  if (timer == '0) begin
                     state <= REPORT;
                     done  <= 1'b1;
                     for (int k = 0; k < 7; k++)
                        recall_result[k] <= (cnt_next[k] >= CNT_W'(SPIKE_THRESH));
                  end else begin
                     timer <= timer - 1'b1;
                  end
               end
               REPORT: begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
               default: begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: doc/hopfield_sequencer.md
Name: hopfield_sequencer

Overview:
- Controller that drives the learning_enable and pattern_input pins of the 7-neuron Hopfield network.
- Stores up to N_PAT 4-bit training patterns written by a host.
- Train job: replays the stored patterns for EPOCHS epochs, each pattern as a present window followed by a rest window.
- Recall job: injects a host cue, lets the network free-run, counts per-neuron spikes and reports a 7-bit recalled pattern.

Parameters:
N_PAT, 4, number of stored patterns (power of 2, >=2)
EPOCHS, 8, passes over all patterns per train job
TRAIN_CYCLES, 200, cycles each pattern is presented with learning on
REST_CYCLES, 50, cycles of learning off / zero input after each presentation
CUE_CYCLES, 20, cycles the recall cue is injected
RECALL_CYCLES, 500, free-run cycles during which spikes are counted
SPIKE_THRESH, 3, minimum spike count for a neuron to read as 1
CNT_W, 16, spike counter width (saturating)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
pat_wr_en  in  1  write strobe for pattern memory
pat_wr_addr  in  log2(N_PAT)  pattern slot
pat_wr_data  in  4  pattern value
train_start  in  1  start-train pulse
recall_start  in  1  start-recall pulse
cue  in  4  recall cue, sampled on accepted recall_start
abort  in  1  cancel the current job
spikes  in  7  spike outputs from the network
learning_enable  out  1  to the network
pattern_input  out  4  to the network
busy  out  1  high whenever state is not IDLE
done  out  1  one-cycle pulse at the normal end of a job
recall_result  out  7  recalled pattern, held until the next recall completes

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: state=IDLE; all pattern slots=0; learning_enable=0; pattern_input=0; busy=0; done=0; recall_result=0; all counters=0.
- States: IDLE, T_PRESENT, T_REST, CUE, RECALL, REPORT.
- Pattern writes:
  - Accepted only in IDLE; slot updates on the same edge.
  - Ignored while busy, so memory is stable during a job.
  - A write in the same cycle as an accepted start does not take effect.
- IDLE exit:
  - train_start=1 -> T_PRESENT with pat_idx=0, epoch=0.
  - Else recall_start=1 -> CUE; cue is latched and all 7 spike counters clear.
  - train_start has priority if both are high.
  - Start pulses outside IDLE are ignored.
- T_PRESENT:
  - learning_enable=1, pattern_input=mem[pat_idx].
  - Lasts exactly TRAIN_CYCLES cycles, then -> T_REST.
- T_REST:
  - learning_enable=0, pattern_input=0, for REST_CYCLES cycles.
  - Then pat_idx increments (wraps at N_PAT, incrementing epoch on wrap).
  - If epoch reaches EPOCHS -> IDLE with done=1 for one cycle; else -> T_PRESENT.
  - Train job length = EPOCHS*N_PAT*(TRAIN_CYCLES+REST_CYCLES) cycles from the first T_PRESENT cycle.
- CUE:
  - learning_enable=1, pattern_input=latched cue, for CUE_CYCLES cycles, then -> RECALL.
  - Input injection in the network is gated by learning_enable, so cue cycles also learn; this is accepted.
- RECALL:
  - learning_enable=0, pattern_input=0, for RECALL_CYCLES cycles.
  - Counter k increments on each 0->1 edge of spikes[k]. A spike held high counts once.
  - The previous-sample register clears at recall start.
  - Counters saturate at 2^CNT_W-1 and do not wrap.
- REPORT (one cycle):
  - recall_result[k] = (count[k] >= SPIKE_THRESH).
  - done=1, then -> IDLE.
- Counting window: spikes during CUE are not counted.
- Outputs: registered; learning_enable and pattern_input change on the edge that enters each state.
- abort:
  - Any state -> IDLE on the next edge.
  - learning_enable=0, pattern_input=0, no done pulse, recall_result unchanged.
  - abort has priority over starts in IDLE.
- Reset mid-job: behaves as reset from power-up; the pattern memory is cleared too.
- Timers: one down-counter, wide enough for the largest cycle parameter. Each parameter must be >=1.

Test Plan (bench params: N_PAT=4, EPOCHS=2, TRAIN_CYCLES=4, REST_CYCLES=2, CUE_CYCLES=3, RECALL_CYCLES=10, SPIKE_THRESH=3):
- Write slots 0..3 = 0x1,0x2,0x4,0x8, pulse train_start -> the following sequence, repeated twice, busy high for 48 cycles, then a single done pulse:
  - 4 cycles learning_enable=1 with pattern_input=0x1
  - 2 cycles learning_enable=0, pattern_input=0
  - then the same for 0x2, 0x4, 0x8
- Recall with cue=0x5, drive spikes[0] with 4 single-cycle pulses and spikes[3] with 2 during RECALL -> recall_result=7'b0000001, done at cycle 3+10+1 after start.
- spikes[2] held high for all of RECALL, plus 3 pulses on spikes[6] during CUE only -> count[2]=1, recall_result=0.
- train_start and recall_start in the same cycle -> train runs. recall_start mid-train -> ignored. pat_wr_en mid-train -> memory unchanged, verified by a second train.
- abort in the 3rd T_PRESENT cycle -> next cycle IDLE, learning_enable=0, pattern_input=0, no done, previous recall_result retained.
- reset asserted during RECALL -> next cycle all outputs 0, all slots read back as 0 (a train emits pattern_input=0).
